// File: rtl/gap_pkg.sv
// gap_pkg: shared widths and FSM state type for the gap_seq sequencer.
// Optional feature macro used by this slice: GAP_SEQ_ECHO_EN (result word echo).
package gap_pkg;

  localparam int WORD_W = 32;
  localparam int GAP_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } gap_seq_state_t;

endpackage

// File: rtl/gap_seq_fifo.sv
// gap_seq_fifo: small synchronous FIFO feeding the gap_seq FSM.
// DEPTH must be a power of two so the pointers wrap naturally.
module gap_seq_fifo
  import gap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gap_seq.sv
// gap_seq: paces buffered words into the gap stage (clear, hold for a scan
// window, capture result) and offers each result with valid/ready.
// Optional macro GAP_SEQ_ECHO_EN adds res_data, the word behind each result.
//
// state | meaning
// IDLE  | gap held in clear, waiting for a buffered word
// CLEAR | one-cycle clear with the new word already on gap_data
// SCAN  | gap running on the held word for WORD_CYCLES cycles
// DONE  | result offered downstream, word still held
module gap_seq
  import gap_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WORD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [WORD_W-1:0] gap_data,
  output logic              gap_rst,
  input  logic [GAP_W-1:0]  gap_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [GAP_W-1:0]  res_gap
`ifdef GAP_SEQ_ECHO_EN
  ,
  output logic [WORD_W-1:0] res_data
`endif
);

  localparam int CNT_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_CYCLES - 1);

  gap_seq_state_t    state;
  gap_seq_state_t    state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] head;
  logic              push;
  logic              pop;
  logic              cap;
  logic              fifo_ne;
  logic              scan_last;
  logic              accept;

  // Full blocks new words even when the FSM pops in the same cycle.
  assign in_ready  = (count < CW'(DEPTH)) && !rst;
  assign push      = in_valid && in_ready;
  assign fifo_ne   = (count != '0);
  assign scan_last = (cnt == CNT_LAST);
  assign accept    = res_valid && res_ready;

  gap_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an accepted result chains straight into the next word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_ne) state_nxt = CLEAR;
      CLEAR:   state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = DONE;
      DONE:    if (accept) state_nxt = fifo_ne ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes: FIFO pop and result capture.
  always_comb begin
    pop = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE:    pop = fifo_ne;
      SCAN:    cap = scan_last;
      DONE:    pop = accept && fifo_ne;
      default: ;
    endcase
  end

  // Registered gap drive, scan counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_rst   <= 1'b1;
      gap_data  <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_gap   <= '0;
    end else begin
      // gap_rst follows the state being entered, so clear and new data land together.
      gap_rst <= (state_nxt == IDLE) || (state_nxt == CLEAR);
      if (pop) gap_data <= head;
      if ((state == SCAN) && !scan_last) cnt <= cnt + 1'b1;
      else                               cnt <= '0;
      if (cap) begin
        res_valid <= 1'b1;
        res_gap   <= gap_in;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef GAP_SEQ_ECHO_EN
  // Echo of the scanned word, captured alongside res_gap.
  always_ff @(posedge clk) begin
    if (rst)      res_data <= '0;
    else if (cap) res_data <= gap_data;
  end
`else
  // No echo register: the scanned word is not retained past gap_data.
`endif

endmodule

// File: tb/tb_gap_seq.sv
// tb_gap_seq: directed and randomized checks of gap_seq driving a behavioural gap stage.
module tb_gap_seq;
  import gap_pkg::*;

  localparam int DEPTH = 4;
  localparam int WC    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic [WORD_W-1:0] gap_data;
  logic              gap_rst;
  logic [GAP_W-1:0]  gap_in;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [GAP_W-1:0]  res_gap;
`ifdef GAP_SEQ_ECHO_EN
  logic [WORD_W-1:0] res_data;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  gap_seq #(.DEPTH(DEPTH), .WORD_CYCLES(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .gap_data  (gap_data),
    .gap_rst   (gap_rst),
    .gap_in    (gap_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_gap   (res_gap)
`ifdef GAP_SEQ_ECHO_EN
    ,
    .res_data  (res_data)
`endif
  );

  always #20 clk = ~clk;

  // Longest run of zeros bounded by ones on both sides.
  function automatic logic [4:0] ref_gap(input logic [31:0] w);
    int  best = 0;
    int  run  = 0;
    bit  seen = 0;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) begin
        if (seen && run > best) best = run;
        seen = 1;
        run  = 0;
      end else begin
        run++;
      end
    end
    return 5'(best);
  endfunction

  // Behavioural gap stage: result only settles after WC-1 un-cleared edges.
  int gcnt = 0;
  always @(posedge clk) begin
    if (gap_rst)          gcnt <= 0;
    else if (gcnt < 1000) gcnt <= gcnt + 1;
  end
  assign gap_in = (gcnt >= WC - 1) ? ref_gap(gap_data) : 5'h1f;

  // Result monitor: handshake edges and valid rise edges.
  logic [4:0] got_q[$];
  int         acc_t[$];
  int         rise_t[$];
  logic       rv_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rv_prev <= res_valid;
    if (!rst && res_valid && res_ready) begin
      got_q.push_back(res_gap);
      acc_t.push_back(cyc + 1);
    end
    if (!rst && res_valid && !rv_prev) rise_t.push_back(cyc);
  end

  // gap_rst falling edges and data changes outside a clear.
  int          falls = 0;
  int          viol  = 0;
  logic        prev_grst = 1'b1;
  logic [31:0] prev_gd   = '0;
  always @(negedge clk) begin
    if (prev_grst && !gap_rst) falls <= falls + 1;
    if ((gap_data !== prev_gd) && (gap_rst === 1'b0)) viol <= viol + 1;
    prev_grst <= gap_rst;
    prev_gd   <= gap_data;
  end

  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    acc_t.delete();
    rise_t.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", in_ready, 1);
    exp_q.push_back(ref_gap(w));
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_results(input int num, input int limit);
    int n = 0;
    while (got_q.size() < num && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic single(input logic [31:0] w, input logic [4:0] g, input string tag);
    int c0;
    res_ready = 1'b0;
    push_word(w);
    c0 = cyc;
    in_valid = 1'b0;
    wait_valid(60);
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_latency"}, cyc - c0, WC + 2);
    check({tag, "_gap"}, res_gap, g);
    check({tag, "_gap_rst"}, gap_rst, 0);
    check({tag, "_gap_data"}, gap_data, w);
`ifdef GAP_SEQ_ECHO_EN
    check({tag, "_res_data"}, res_data, w);
`endif
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_cleared"}, res_valid, 0);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[12];
    logic [4:0]  held;
    int          idx;
    int          n;
    int          c0;
    int          f0;
    int          bad;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_gap_rst", gap_rst, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_gap", res_gap, 0);
    check("rst_gap_data", gap_data, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single words
    single(32'hFFFF_FFFF, 5'd0, "w_ffffffff");
    single(32'hFFFF_7FBF, 5'd1, "w_ffff7fbf");
    single(32'h59EB_FB8E, 5'd3, "w_59ebfb8e");

    // Three back-to-back words with res_ready held high
    clear_q();
    f0 = falls;
    res_ready = 1'b1;
    push_word(32'hFFFF_FFFF);
    push_word(32'hFFFF_7FBF);
    push_word(32'h59EB_FB8E);
    in_valid = 1'b0;
    wait_results(3, 300);
    repeat (3) @(negedge clk);
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() == 3 && rise_t.size() == 3) begin
      check("b2b_r0", got_q[0], 0);
      check("b2b_r1", got_q[1], 1);
      check("b2b_r2", got_q[2], 3);
      // accept of one result to the valid of the next
      check("b2b_space01", rise_t[1] - acc_t[0], WC + 1);
      check("b2b_space12", rise_t[2] - acc_t[1], WC + 1);
    end
    check("b2b_gap_rst_pulses", falls - f0, 3);

    // Backpressure: five words, consumer stalled
    clear_q();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    in_valid = 1'b0;
    check("bp_in_ready_full", in_ready, 0);
    wait_valid(60);
    check("bp_valid", res_valid, 1);
    held = res_gap;
    repeat (25) @(negedge clk);
    check("bp_valid_held", res_valid, 1);
    check("bp_gap_held", res_gap, held);
    check("bp_first_gap", res_gap, exp_q[0]);
    check("bp_still_full", in_ready, 0);
    res_ready = 1'b1;
    wait_results(5, 400);
    check("bp_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check($sformatf("bp_r%0d", i), got_q[i], exp_q[i]);

    // Randomized traffic with random consumer stalls
    clear_q();
    for (int i = 0; i < 12; i++) words[i] = $urandom;
    idx = 0;
    n = 0;
    while ((idx < 12 || got_q.size() < 12) && n < 3000) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (idx < 12) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_gap(words[idx]));
        idx++;
      end
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b0;
    res_ready = 1'b0;
    check("rand_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      check($sformatf("rand_r%0d", i), got_q[i], exp_q[i]);

    // Reset in the middle of SCAN with a second word buffered
    clear_q();
    res_ready = 1'b0;
    push_word(32'hFFFF_7FBF);
    c0 = cyc;
    push_word(32'h59EB_FB8E);
    in_valid = 1'b0;
    // counter is 7 during the cycle WC-independent: CLEAR at c0+1, SCAN from c0+2
    while (cyc < c0 + 9) @(negedge clk);
    check("mid_in_scan", gap_rst, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_gap_rst", gap_rst, 1);
    check("mid_res_valid", res_valid, 0);
    check("mid_gap_data", gap_data, 0);
    check("mid_res_gap", res_gap, 0);
    check("mid_in_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || gap_rst !== 1'b1) bad++;
    end
    check("mid_fifo_empty", bad, 0);
    single(32'h59EB_FB8E, 5'd3, "mid_after");

    check("gap_data_only_on_clear", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
